mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the ALU in the 16-bit CPU.
- Consumes each EX-stage instruction word together with the ALU result and flag.
- For LW, LW_SP, SW and SW_SP, uses the ALU result as the effective address and runs a request/acknowledge transaction on the data-memory port.
- Every instruction (memory or not) retires in program order to the writeback stage. Upstream is stalled while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs req/ack transactions for loads/stores and
// retires every accepted instruction in program order to writeback.
//   state  | meaning
//   IDLE   | ready to accept an EX-stage instruction
//   ACCESS | memory transaction outstanding, upstream stalled
module mem_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [15:0]       ex_opn,
  input  logic [DATA_W-1:0] ex_res,
  input  logic              ex_flag,
  input  logic [DATA_W-1:0] ex_sdata,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic              ex_wen,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_wen,
  output logic [REG_W-1:0]  wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_flag
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic             is_load, is_store, is_mem;
  logic             accept, ack;
  logic [REG_W-1:0] lat_dst;
  logic             lat_wen, lat_flag;
  logic             unused_opn;

  assign is_load  = (ex_opn[15:11] == 5'b10011) || (ex_opn[15:11] == 5'b10010);
  assign is_store = (ex_opn[15:11] == 5'b11011) || (ex_opn[15:11] == 5'b11010);
  assign is_mem   = is_load | is_store;
  assign unused_opn = ^ex_opn[10:0];

  assign accept  = ex_valid & ~flush & (state == IDLE);
  // ack only counts while a request is actually outstanding
  assign ack     = mem_ack & (state == ACCESS);
  assign stall   = (state == ACCESS);
  assign mem_req = (state == ACCESS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept && is_mem) state_nxt = ACCESS;
      ACCESS: if (mem_ack)          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_dst   <= '0;
      lat_wen   <= 1'b0;
      lat_flag  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_wen    <= 1'b0;
      wb_dst    <= '0;
      wb_data   <= '0;
      wb_flag   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid <= 1'b1;
        wb_data  <= ex_res;
        wb_dst   <= ex_dst;
        wb_wen   <= ex_wen;
        wb_flag  <= ex_flag;
      end
      if (accept && is_mem) begin
        mem_we    <= is_store;
        mem_addr  <= ex_res;
        mem_wdata <= ex_sdata;
        lat_dst   <= ex_dst;
        lat_wen   <= ex_wen;
        lat_flag  <= ex_flag;
      end
      // stores retire their address and never write a register
      if (ack) begin
        wb_valid <= 1'b1;
        wb_dst   <= lat_dst;
        wb_flag  <= lat_flag;
        wb_wen   <= mem_we ? 1'b0 : lat_wen;
        wb_data  <= mem_we ? mem_addr : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized
// instruction streams checked against a transaction-level model.
module tb_mem_stage;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_flag, ex_wen, flush;
  logic [15:0]       ex_opn;
  logic [DATA_W-1:0] ex_res, ex_sdata;
  logic [REG_W-1:0]  ex_dst;
  logic              stall, mem_req, mem_we, mem_ack;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              wb_valid, wb_wen, wb_flag;
  logic [REG_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_data;

  int checks = 0;
  int passes = 0;

  // last retired values, which wb_* must hold between retires
  logic [DATA_W-1:0] last_data;
  logic [REG_W-1:0]  last_dst;
  logic              last_wen, last_flag;

  localparam logic [15:0] OP_ADDU  = 16'hE001;
  localparam logic [15:0] OP_LI    = 16'h6A05;
  localparam logic [15:0] OP_OR    = 16'hE80D;
  localparam logic [15:0] OP_LW    = 16'h9840;
  localparam logic [15:0] OP_LW_SP = 16'h9203;
  localparam logic [15:0] OP_SW    = 16'hD860;
  localparam logic [15:0] OP_SW_SP = 16'hD207;

  mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opn(ex_opn), .ex_res(ex_res),
    .ex_flag(ex_flag), .ex_sdata(ex_sdata), .ex_dst(ex_dst), .ex_wen(ex_wen),
    .flush(flush), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dst(wb_dst),
    .wb_data(wb_data), .wb_flag(wb_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit op_is_load(input logic [15:0] op);
    return (op[15:11] == 5'b10011) || (op[15:11] == 5'b10010);
  endfunction

  function automatic bit op_is_store(input logic [15:0] op);
    return (op[15:11] == 5'b11011) || (op[15:11] == 5'b11010);
  endfunction

  task automatic chk_retire(input string tag);
    chk({tag, ".wb_valid"}, wb_valid,  1'b1);
    chk({tag, ".wb_data"},  wb_data,   last_data);
    chk({tag, ".wb_dst"},   wb_dst,    last_dst);
    chk({tag, ".wb_wen"},   wb_wen,    last_wen);
    chk({tag, ".wb_flag"},  wb_flag,   last_flag);
  endtask

  // Offer one instruction and follow it to retirement, predicting everything
  // from the instruction's class alone.
  task automatic issue(input string tag, input logic [15:0] op, input logic [15:0] res,
                       input logic [15:0] sdata, input logic [3:0] dst, input logic wen,
                       input logic flag, input logic fl, input int waits,
                       input logic [15:0] rdata);
    bit ld, st;
    ld = op_is_load(op);
    st = op_is_store(op);
    ex_valid = 1'b1; ex_opn = op; ex_res = res; ex_sdata = sdata;
    ex_dst = dst; ex_wen = wen; ex_flag = flag; flush = fl;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    step();
    ex_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    if (fl) begin
      chk({tag, ".flush_req"},   mem_req,  1'b0);
      chk({tag, ".flush_wb"},    wb_valid, 1'b0);
      chk({tag, ".flush_hold"},  wb_data,  last_data);
      return;
    end
    if (!ld && !st) begin
      last_data = res; last_dst = dst; last_wen = wen; last_flag = flag;
      chk_retire(tag);
      chk({tag, ".req"}, mem_req, 1'b0);
      chk({tag, ".stall"}, stall, 1'b0);
      return;
    end
    chk({tag, ".accept_wb"}, wb_valid, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, ".req"},   mem_req,   1'b1);
      chk({tag, ".stall"}, stall,     1'b1);
      chk({tag, ".we"},    mem_we,    st);
      chk({tag, ".addr"},  mem_addr,  res);
      chk({tag, ".wdata"}, mem_wdata, sdata);
      // upstream noise during ACCESS, including a flush, must change nothing
      ex_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      flush    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ex_opn = 16'($urandom); ex_res = 16'($urandom); ex_sdata = 16'($urandom);
      ex_dst = 4'($urandom); ex_wen = 1'($urandom_range(0, 1));
      mem_ack = (i == waits);
      mem_rdata = (i == waits) ? rdata : 16'($urandom);
      step();
      if (i < waits) chk({tag, ".wait_wb"}, wb_valid, 1'b0);
    end
    ex_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    last_data = ld ? rdata : res;
    last_dst = dst; last_wen = ld ? wen : 1'b0; last_flag = flag;
    chk_retire(tag);
    chk({tag, ".req_drop"},   mem_req, 1'b0);
    chk({tag, ".stall_drop"}, stall,   1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'($urandom_range(0, 1));
      flush = ex_valid;
      ex_opn = OP_LW; ex_res = 16'($urandom);
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
      step();
      chk("idle.wb_valid", wb_valid, 1'b0);
      chk("idle.req",      mem_req,  1'b0);
      chk("idle.hold",     wb_data,  last_data);
      chk("idle.hold_dst", wb_dst,   last_dst);
    end
    ex_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_opn = '0; ex_res = '0; ex_sdata = '0; ex_dst = '0;
    ex_wen = 1'b0; ex_flag = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    last_data = '0; last_dst = '0; last_wen = 1'b0; last_flag = 1'b0;
    #12;
    chk("rst.stall",    stall,     1'b0);
    chk("rst.req",      mem_req,   1'b0);
    chk("rst.we",       mem_we,    1'b0);
    chk("rst.addr",     mem_addr,  16'h0);
    chk("rst.wdata",    mem_wdata, 16'h0);
    chk("rst.wb_valid", wb_valid,  1'b0);
    chk("rst.wb_data",  wb_data,   16'h0);
    chk("rst.wb_dst",   wb_dst,    4'h0);
    rst = 1'b0;
    step();

    issue("addu", OP_ADDU, 16'h0003, 16'h1111, 4'd1, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    issue("li",   OP_LI,   16'h00FF, 16'h2222, 4'd2, 1'b1, 1'b1, 1'b0, 0, 16'h0);
    issue("or",   OP_OR,   16'h1234, 16'h3333, 4'd3, 1'b1, 1'b0, 1'b0, 0, 16'h0);
    idle(1);

    issue("lw3", OP_LW, 16'h8000, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0, 2, 16'hBEEF);
    chk("lw3.const_data", wb_data, 16'hBEEF);
    idle(1);

    issue("swsp", OP_SW_SP, 16'hFFFF, 16'h5A5A, 4'd9, 1'b1, 1'b1, 1'b0, 0, 16'hAAAA);
    chk("swsp.const_wen", wb_wen, 1'b0);
    idle(1);

    // LW followed by an ADDU that upstream holds under stall
    ex_valid = 1'b1; ex_opn = OP_LW; ex_res = 16'h1000; ex_dst = 4'd3;
    ex_wen = 1'b1; ex_flag = 1'b0; ex_sdata = 16'h0;
    step();
    chk("b2b.req", mem_req, 1'b1);
    ex_opn = OP_ADDU; ex_res = 16'h0042; ex_dst = 4'd5; ex_flag = 1'b1;
    step();
    chk("b2b.held_wb", wb_valid, 1'b0);
    chk("b2b.stall",   stall,    1'b1);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    step();
    mem_ack = 1'b0;
    last_data = 16'h7777; last_dst = 4'd3; last_wen = 1'b1; last_flag = 1'b0;
    chk_retire("b2b.lw");
    step();
    ex_valid = 1'b0;
    last_data = 16'h0042; last_dst = 4'd5; last_wen = 1'b1; last_flag = 1'b1;
    chk_retire("b2b.addu");
    chk("b2b.addu_req", mem_req, 1'b0);
    idle(2);

    issue("flush_sw", OP_SW, 16'h4444, 16'h5555, 4'd1, 1'b0, 1'b0, 1'b1, 0, 16'h0);
    issue("flush_mid", OP_LW_SP, 16'h0010, 16'h0, 4'd7, 1'b1, 1'b1, 1'b0, 3, 16'hC0DE);

    // asynchronous reset two cycles into a load
    ex_valid = 1'b1; ex_opn = OP_LW; ex_res = 16'h2468; ex_dst = 4'd6; ex_wen = 1'b1;
    step();
    ex_valid = 1'b0;
    step();
    chk("rstmid.req_before", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.req",   mem_req,  1'b0);
    chk("rstmid.stall", stall,    1'b0);
    chk("rstmid.addr",  mem_addr, 16'h0);
    chk("rstmid.wb",    wb_data,  16'h0);
    #2 rst = 1'b0;
    last_data = '0; last_dst = '0; last_wen = 1'b0; last_flag = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_ack = 1'b0;
    chk("rstmid.late_ack_wb",  wb_valid, 1'b0);
    chk("rstmid.late_ack_req", mem_req,  1'b0);
    chk("rstmid.late_ack_data", wb_data, 16'h0);

    for (int n = 0; n < 150; n++) begin
      int cls;
      logic [15:0] op;
      cls = $urandom_range(0, 4);
      op = 16'($urandom);
      case (cls)
        1: op[15:11] = $urandom_range(0, 1) ? 5'b10011 : 5'b10010;
        2: op[15:11] = $urandom_range(0, 1) ? 5'b11011 : 5'b11010;
        default: while (op_is_load(op) || op_is_store(op)) op = 16'($urandom);
      endcase
      issue("rand", op, 16'($urandom), 16'($urandom), 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (cls == 4) ? 1'b1 : 1'b0, $urandom_range(0, 4), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
